// File: rtl/conc_pkg.sv
// Shared types for the conc32 word packer.
// Packed word layout is {data, load}, load in bit 0.
package conc_pkg;

  localparam int DATA_W = 32;
  localparam int PACK_W = DATA_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              load;
  } packed_word_t;

  function automatic packed_word_t pack_word(
    input logic [DATA_W-1:0] data,
    input logic              load
  );
    packed_word_t w;
    w.data = data;
    w.load = load;
    return w;
  endfunction

endpackage

// File: rtl/conc32_packer_if.sv
// Bus bundle between a producer and the conc32 packer.
// Master drives the word and flag, slave returns the packed result.
interface conc32_packer_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);

  logic [DATA_W-1:0] data_in;
  logic              LOAD;
  logic              en;
  logic [DATA_W:0]   data_out;
  logic              parity_out;
  logic              out_valid;
  logic [CNT_W-1:0]  load_count;

  modport master (
    output data_in,
    output LOAD,
    output en,
    input  data_out,
    input  parity_out,
    input  out_valid,
    input  load_count
  );

  modport slave (
    input  data_in,
    input  LOAD,
    input  en,
    output data_out,
    output parity_out,
    output out_valid,
    output load_count
  );

endinterface

// File: rtl/conc_pipe_stage.sv
// One enabled, synchronously reset register of a packed word.
// A valid bit travels alongside the word.
module conc_pipe_stage
  import conc_pkg::*;
#(
  parameter type T = packed_word_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  T     i_word,
  input  logic i_valid,
  output T     o_word,
  output logic o_valid
);

  T     r_word;
  logic r_valid;

  // capture word and valid on enabled edges, clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word  <= '0;
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_word  <= i_word;
      r_valid <= i_valid;
    end
  end

  assign o_word  = r_word;
  assign o_valid = r_valid;

endmodule

// File: rtl/conc32_packer.sv
// Packs {data_in, LOAD} into one bus word with optional pipeline,
// even parity, a valid flag and a saturating LOAD counter.
module conc32_packer #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 0,
  parameter int CNT_W       = 16
) (
  input logic             clk,
  input logic             rst,
  conc32_packer_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              load;
  } word_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  word_t            w_in;
  word_t            w_out;
  logic             w_valid;
  logic [CNT_W-1:0] r_cnt;

  assign w_in.data = bus.data_in;
  assign w_in.load = bus.LOAD;

  if (PIPE_STAGES == 0) begin : g_comb
    assign w_out   = w_in;
    assign w_valid = 1'b1;
  end else begin : g_pipe
    word_t w_word [PIPE_STAGES+1];
    logic  w_vld  [PIPE_STAGES+1];

    assign w_word[0] = w_in;
    assign w_vld[0]  = 1'b1;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
      conc_pipe_stage #(
        .T (word_t)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_en    (bus.en),
        .i_word  (w_word[k]),
        .i_valid (w_vld[k]),
        .o_word  (w_word[k+1]),
        .o_valid (w_vld[k+1])
      );
    end

    assign w_out   = w_word[PIPE_STAGES];
    assign w_valid = w_vld[PIPE_STAGES];
  end

  // count enabled LOAD cycles, holding at the top value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (bus.en && bus.LOAD && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign bus.data_out   = w_out;
  assign bus.parity_out = ^w_out;
  assign bus.out_valid  = w_valid;
  assign bus.load_count = r_cnt;

endmodule

// File: tb/tb_conc32_packer.sv
// Bench for conc32_packer: three instances (0/1/2 stages)
// checked against a queue-based reference of enabled words.
module tb_conc32_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        ld;
  logic        en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conc32_packer_if #(.DATA_W(32), .CNT_W(16)) if0 ();
  conc32_packer_if #(.DATA_W(32), .CNT_W(4))  if1 ();
  conc32_packer_if #(.DATA_W(32), .CNT_W(16)) if2 ();

  assign if0.data_in = data;
  assign if0.LOAD    = ld;
  assign if0.en      = en;
  assign if1.data_in = data;
  assign if1.LOAD    = ld;
  assign if1.en      = en;
  assign if2.data_in = data;
  assign if2.LOAD    = ld;
  assign if2.en      = en;

  conc32_packer #(.DATA_W(32), .PIPE_STAGES(0), .CNT_W(16)) dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );
  conc32_packer #(.DATA_W(32), .PIPE_STAGES(1), .CNT_W(4)) dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );
  conc32_packer #(.DATA_W(32), .PIPE_STAGES(2), .CNT_W(16)) dut2 (
    .clk (clk), .rst (rst), .bus (if2.slave)
  );

  // reference: words accepted on enabled edges since reset, newest first
  logic [32:0] hist [$];
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      m_cnt = 0;
    end else if (en) begin
      hist.push_front({data, ld});
      if (hist.size() > 2) void'(hist.pop_back());
      if (ld) m_cnt = m_cnt + 1;
    end
  end

  function automatic logic [32:0] exp_word(int n);
    if (hist.size() >= n) return hist[n-1];
    return 33'd0;
  endfunction

  function automatic logic exp_vld(int n);
    return hist.size() >= n;
  endfunction

  function automatic int exp_cnt(int maxv);
    return (m_cnt > maxv) ? maxv : m_cnt;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    logic [32:0] w;
    w = {data, ld};
    chk({tag, "_d0"}, 64'(if0.data_out), 64'(w));
    chk({tag, "_p0"}, 64'(if0.parity_out), 64'(^w));
    chk({tag, "_v0"}, 64'(if0.out_valid), 64'd1);
    chk({tag, "_c0"}, 64'(if0.load_count), 64'(exp_cnt(65535)));
    w = exp_word(1);
    chk({tag, "_d1"}, 64'(if1.data_out), 64'(w));
    chk({tag, "_p1"}, 64'(if1.parity_out), 64'(^w));
    chk({tag, "_v1"}, 64'(if1.out_valid), 64'(exp_vld(1)));
    chk({tag, "_c1"}, 64'(if1.load_count), 64'(exp_cnt(15)));
    w = exp_word(2);
    chk({tag, "_d2"}, 64'(if2.data_out), 64'(w));
    chk({tag, "_p2"}, 64'(if2.parity_out), 64'(^w));
    chk({tag, "_v2"}, 64'(if2.out_valid), 64'(exp_vld(2)));
    chk({tag, "_c2"}, 64'(if2.load_count), 64'(exp_cnt(65535)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [32:0] e_out;
    logic        e_par;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{32'd255,       1'b0, 33'h1FE,       1'b0};
    vecs[1] = '{32'd255,       1'b1, 33'h1FF,       1'b1};
    vecs[2] = '{32'hFFFFFFFF,  1'b1, 33'h1FFFFFFFF, 1'b1};
    vecs[3] = '{32'h0,         1'b0, 33'h0,         1'b0};
    vecs[4] = '{32'hA5A5A5A5,  1'b1, 33'h14B4B4B4B, 1'b1};
    vecs[5] = '{32'h80000000,  1'b0, 33'h100000000, 1'b1};

    rst  = 1'b1;
    data = 32'h0;
    ld   = 1'b0;
    en   = 1'b0;
    tick();
    chk("rst_out1", 64'(if1.data_out), 64'd0);
    chk("rst_vld2", 64'(if2.out_valid), 64'd0);
    chk("rst_par2", 64'(if2.parity_out), 64'd0);
    chk("rst_vld0", 64'(if0.out_valid), 64'd1);
    check_all("rst");

    // combinational path follows inputs even in reset
    data = 32'h12345678;
    ld   = 1'b1;
    #1;
    chk("rst_comb", 64'(if0.data_out), 64'h0_2468ACF1);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      data = vecs[i].d;
      ld   = vecs[i].l;
      #2;
      chk($sformatf("vec%0d_out", i), 64'(if0.data_out), 64'(vecs[i].e_out));
      chk($sformatf("vec%0d_par", i), 64'(if0.parity_out), 64'(vecs[i].e_par));
      chk($sformatf("vec%0d_vld", i), 64'(if0.out_valid), 64'd1);
    end

    // two-stage latency and hold
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    en   = 1'b1;
    data = 32'hA5A5A5A5;
    ld   = 1'b1;
    tick();
    chk("lat_v_e1", 64'(if2.out_valid), 64'd0);
    chk("lat_d_e1", 64'(if2.data_out), 64'd0);
    tick();
    chk("lat_v_e2", 64'(if2.out_valid), 64'd1);
    chk("lat_d_e2", 64'(if2.data_out), 64'h1_4B4B4B4B);
    en   = 1'b0;
    data = 32'h00000123;
    ld   = 1'b0;
    tick();
    tick();
    chk("hold_d2", 64'(if2.data_out), 64'h1_4B4B4B4B);
    chk("hold_d1", 64'(if1.data_out), 64'h1_4B4B4B4B);
    check_all("hold");

    // counter gating
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b1;
    ld  = 1'b1;
    repeat (5) tick();
    ld = 1'b0;
    repeat (3) tick();
    en = 1'b0;
    ld = 1'b1;
    repeat (2) tick();
    chk("cnt5_0", 64'(if0.load_count), 64'd5);
    chk("cnt5_1", 64'(if1.load_count), 64'd5);
    rst = 1'b1;
    tick();
    chk("cnt_rst", 64'(if0.load_count), 64'd0);
    rst = 1'b0;

    // saturation on the 4-bit counter
    en = 1'b1;
    ld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data = $urandom;
      tick();
    end
    chk("sat_1", 64'(if1.load_count), 64'd15);
    chk("sat_0", 64'(if0.load_count), 64'd20);
    repeat (5) tick();
    chk("sat_hold", 64'(if1.load_count), 64'd15);

    // reset mid-pipeline
    data = 32'hDEADBEEF;
    tick();
    chk("mid_pre", 64'(if1.data_out), 64'h1_BD5B7DDF);
    chk("mid_pre_v", 64'(if1.out_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_d", 64'(if1.data_out), 64'd0);
    chk("mid_v", 64'(if1.out_valid), 64'd0);
    chk("mid_p", 64'(if1.parity_out), 64'd0);
    check_all("mid");

    // randomized run against the reference
    for (int i = 0; i < 400; i++) begin
      data = $urandom;
      ld   = 1'($urandom_range(0, 1));
      en   = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 39) == 0);
      tick();
      check_all($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conc32_packer.md
Name:
conc32_packer

Overview:
- Packs a 32-bit data word and a 1-bit LOAD control flag into one 33-bit bus word, laid out as {data_in, LOAD}.
- Used in the CPU datapath wherever a data word must travel with its load qualifier on a single bus.
- The pipeline depth is configurable (0 = pure combinational path).
- Also provides a parity bit, a valid flag and a saturating LOAD-event counter for debug and bus checking.

Parameters:
- DATA_W, 32: width of data_in; data_out is DATA_W+1 bits wide.
- PIPE_STAGES, 0: register stages between the inputs and data_out. Legal values are 0, 1 and 2.
- CNT_W, 16: width of load_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  data word to pack.
- LOAD  in  1  load qualifier flag; becomes bit 0 of data_out.
- en  in  1  pipeline advance and counter enable. Ignored by the combinational path when PIPE_STAGES=0.
- data_out  out  DATA_W+1  packed word {data_in, LOAD} (after PIPE_STAGES stages).
- parity_out  out  1  XOR-reduction of data_out (even parity over all 33 bits), aligned with data_out.
- out_valid  out  1  data_out holds a word that was genuinely packed since reset.
- load_count  out  CNT_W  saturating count of enabled cycles with LOAD=1.

Behaviour:
- Packing rule: data_out[DATA_W:1] = data_in, data_out[0] = LOAD. There is no inversion, sign extension or reordering.
- PIPE_STAGES=0:
  - data_out and parity_out are purely combinational from data_in and LOAD, in the same delta, independent of clk, rst and en.
  - out_valid is tied to 1.
- PIPE_STAGES=N>0:
  - A shift chain of N registers, each holding {data_in, LOAD} plus a valid bit.
  - Stage 0 loads the inputs and valid=1 on a rising edge with en=1.
  - Stage k loads stage k-1 on the same edge.
  - With en=0, all stages hold.
  - data_out, parity_out and out_valid come from the last stage.
  - Latency is exactly N enabled clock edges.
- Reset (rst=1 on a rising edge):
  - All pipeline registers clear to 0 and out_valid clears to 0.
  - load_count clears to 0.
  - Reset wins over en.
  - With PIPE_STAGES=0, data_out still follows the inputs during reset.
- Reset mid-stream: words in flight are discarded. out_valid rises again only after N further enabled edges.
- parity_out: computed from the data_out value actually presented, so it is always consistent with data_out. Reset value is 0 (matching data_out=0).
- load_count:
  - Increments by 1 on each rising edge with rst=0, en=1, LOAD=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Counts for every PIPE_STAGES setting; for PIPE_STAGES=0, en still gates counting.
- No X propagation from the reset state: every register has a defined reset value.

Decomposition:
- Shared package conc_pkg holds:
  - localparam PACK_W = DATA_W+1.
  - typedef packed struct packed_word_t {logic [DATA_W-1:0] data; logic load;}, so the bit order matches {data, load}.
  - function pack_word(data, load) returning packed_word_t.
- One sub-module, conc_pipe_stage: a single enabled, synchronously reset register of packed_word_t plus a valid bit.
  - Instantiated PIPE_STAGES times through a generate loop.
  - Bypassed entirely when PIPE_STAGES=0.
- The parity and counter logic stay in the top level.

Test Plan:
- PIPE_STAGES=0, data_in=32'd255, LOAD=0, wait 10ns -> data_out=33'h1FE, parity_out=0, out_valid=1.
- PIPE_STAGES=0, data_in=32'd255, LOAD=1, wait 10ns -> data_out=33'h1FF, parity_out=1.
- PIPE_STAGES=0, data_in=32'hFFFFFFFF, LOAD=1 -> data_out=33'h1FFFFFFFF; data_in=0, LOAD=0 -> data_out=0. Checks the MSB and LSB boundaries.
- PIPE_STAGES=2, reset then en=1:
  - Apply 32'hA5A5A5A5/LOAD=1.
  - data_out=33'h14B4B4B4B with out_valid=1 after exactly 2 edges.
  - out_valid=0 before then; holding en=0 freezes the output.
- Counter: 5 enabled cycles with LOAD=1, 3 with LOAD=0, 2 with en=0/LOAD=1 -> load_count=5. Assert rst -> load_count=0 on the next edge.
- Saturation with CNT_W=4: 20 enabled LOAD=1 cycles -> load_count=15 and stays 15. Asserting rst mid-pipeline (PIPE_STAGES=1) -> data_out=0, out_valid=0 on the next edge.
